// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader state encoding and the byte-packing helper.
package inst_rom_loader_pkg;

    localparam logic [31:0] NOP_INST_DEF = 32'h00000013;
    localparam logic [31:0] ZERO_WORD    = 32'h00000000;

    typedef enum logic [1:0] {
        LD_STATE_LOAD = 2'd0,
        LD_STATE_PAD  = 2'd1,
        LD_STATE_RUN  = 2'd2
    } ld_state_e;

    // Little-endian lane insert: byte index 0 lands in bits 7:0.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  b);
        logic [31:0] res;
        res = word;
        res[{idx, 3'b000} +: 8] = b;
        return res;
    endfunction

endpackage

// File: rtl/inst_rom_loader_inst_ram.sv
// Instruction store: one synchronous write port for the loader and one
// asynchronous read port for the core's fetch path.
module inst_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // No reset: contents survive a reload and are simply overwritten.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// Fetch responder with a byte-serial load port. Holds the core in reset
// while an image is streamed in, pads a trailing partial word, then releases it.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [31:0]       addr_i,
    output logic [31:0]       inst_o,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_byte_i,
    output logic              ld_ready_o,
    input  logic              ld_done_i,
    output logic              core_hold_o,
    output logic [ADDR_W:0]   ld_count_o,
    output logic              err_o
);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    ld_state_e       state_q, state_d;
    logic [ADDR_W:0] ptr_q, ptr_d;
    logic [1:0]      idx_q, idx_d;
    logic [31:0]     shift_q, shift_d;
    logic            err_q, err_d;
    logic            hold_q, hold_d;
    logic            ready_q, ready_d;

    logic            ram_we;
    logic [31:0]     ram_wdata;
    logic [31:0]     ram_rdata;
    logic [31:0]     packed_word;
    logic            ptr_full;
    logic            byte_acc;
    logic            unused_addr_lsb;

    // ptr never exceeds the depth, so its MSB alone marks a full memory.
    assign ptr_full = ptr_q[ADDR_W];
    assign byte_acc = ld_valid_i & ready_q & (state_q == LD_STATE_LOAD);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        err_d       = err_q;
        ram_we      = 1'b0;
        ram_wdata   = shift_q;
        packed_word = insert_byte(shift_q, idx_q, ld_byte_i);

        if (ld_start_i) begin
            state_d = LD_STATE_LOAD;
            ptr_d   = '0;
            idx_d   = '0;
            shift_d = ZERO_WORD;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                LD_STATE_LOAD: begin
                    if (byte_acc) begin
                        if (ptr_full) begin
                            err_d = 1'b1;
                        end else if (idx_q == 2'd3) begin
                            ram_we    = 1'b1;
                            ram_wdata = packed_word;
                            ptr_d     = ptr_q + PTR_ONE;
                            idx_d     = '0;
                            shift_d   = ZERO_WORD;
                        end else begin
                            shift_d = packed_word;
                            idx_d   = idx_q + 2'd1;
                        end
                    end
                    // Done sees the byte accepted in the same cycle.
                    if (ld_done_i) begin
                        state_d = (idx_d == 2'd0) ? LD_STATE_RUN : LD_STATE_PAD;
                    end
                end
                LD_STATE_PAD: begin
                    if (!ptr_full) begin
                        ram_we    = 1'b1;
                        ram_wdata = shift_q;
                        ptr_d     = ptr_q + PTR_ONE;
                    end
                    idx_d   = '0;
                    shift_d = ZERO_WORD;
                    state_d = LD_STATE_RUN;
                end
                LD_STATE_RUN: begin
                end
                default: begin
                    state_d = LD_STATE_LOAD;
                end
            endcase
        end

        // Registered handshake outputs follow the next state so they flip
        // on the same edge the FSM does.
        hold_d  = (state_d != LD_STATE_RUN);
        ready_d = (state_d == LD_STATE_LOAD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LD_STATE_LOAD;
            ptr_q   <= '0;
            idx_q   <= '0;
            shift_q <= ZERO_WORD;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
            ready_q <= ready_d;
        end
    end

    inst_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ptr_q[ADDR_W-1:0]),
        .wdata_i (ram_wdata),
        .raddr_i (addr_i[ADDR_W+1:2]),
        .rdata_o (ram_rdata)
    );

    // Word-granular fetch; the byte offset bits carry no meaning here.
    assign unused_addr_lsb = ^addr_i[1:0];

    always_comb begin
        inst_o = ZERO_WORD;
        if (ce_i) begin
            if (hold_q || (addr_i[31:ADDR_W+2] != '0)) begin
                inst_o = NOP_INST;
            end else begin
                inst_o = ram_rdata;
            end
        end
    end

    assign ld_ready_o  = ready_q;
    assign core_hold_o = hold_q;
    assign ld_count_o  = ptr_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: two instances (deep and tiny memory),
// expectations from a byte-queue reference model, checked by a monitor.
module tb_inst_rom_loader;

    localparam int          AW0 = 10;
    localparam int          AW1 = 2;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam int K_INST = 0, K_CNT = 1, K_HOLD = 2, K_ERR = 3, K_RDY = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0, ce = 1'b0, ld_start = 1'b0, ld_valid = 1'b0, ld_done = 1'b0;
    logic        probe_vld = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [7:0]  ld_byte = 8'h0;

    logic [31:0] inst0, inst1;
    logic        rdy0, rdy1, hold0, hold1, err0, err1;
    logic [AW0:0] cnt0;
    logic [AW1:0] cnt1;

    inst_rom_loader #(.ADDR_W(AW0)) dut (
        .clk(clk), .rst(rst), .ce_i(ce & ~sel), .addr_i(addr), .inst_o(inst0),
        .ld_start_i(ld_start & ~sel), .ld_valid_i(ld_valid & ~sel), .ld_byte_i(ld_byte),
        .ld_ready_o(rdy0), .ld_done_i(ld_done & ~sel), .core_hold_o(hold0),
        .ld_count_o(cnt0), .err_o(err0)
    );

    inst_rom_loader #(.ADDR_W(AW1)) dut_small (
        .clk(clk), .rst(rst), .ce_i(ce & sel), .addr_i(addr), .inst_o(inst1),
        .ld_start_i(ld_start & sel), .ld_valid_i(ld_valid & sel), .ld_byte_i(ld_byte),
        .ld_ready_o(rdy1), .ld_done_i(ld_done & sel), .core_hold_o(hold1),
        .ld_count_o(cnt1), .err_o(err1)
    );

    typedef struct {
        int          kind;
        bit          s;
        logic [31:0] exp;
        string       nm;
    } item_t;

    item_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: bytes accepted since the last start, plus image contents.
    logic [7:0]  bq0[$], bq1[$];
    logic [31:0] mem0 [0:(1<<AW0)-1];
    logic [31:0] mem1 [0:(1<<AW1)-1];
    int          words0 = 0;

    function automatic int depth(input bit s);
        return s ? (1 << AW1) : (1 << AW0);
    endfunction

    function automatic int nbytes(input bit s);
        return s ? bq1.size() : bq0.size();
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [31:0] actual(input int kind, input bit s);
        case (kind)
            K_INST:  return s ? inst1 : inst0;
            K_CNT:   return s ? 32'(cnt1) : 32'(cnt0);
            K_HOLD:  return {31'd0, s ? hold1 : hold0};
            K_ERR:   return {31'd0, s ? err1 : err0};
            default: return {31'd0, s ? rdy1 : rdy0};
        endcase
    endfunction

    item_t mon_it;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        if (probe_vld) begin
            while (exp_q.size() > 0) begin
                mon_it  = exp_q.pop_front();
                mon_act = actual(mon_it.kind, mon_it.s);
                checks++;
                if (mon_act !== mon_it.exp) begin
                    errors++;
                    $display("FAIL %s (dut%0d): got %h, expected %h",
                             mon_it.nm, mon_it.s, mon_act, mon_it.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        probe_vld = 1'b1;
        tick();
        probe_vld = 1'b0;
    endtask

    task automatic expect_v(input int kind, input bit s, input logic [31:0] v, input string nm);
        item_t it;
        it.kind = kind; it.s = s; it.exp = v; it.nm = nm;
        exp_q.push_back(it);
    endtask

    task automatic expect_status(input bit s, input int cnt, input bit hold, input bit err,
                                 input bit rdy, input string tag);
        expect_v(K_CNT,  s, 32'(cnt),   {tag, ".count"});
        expect_v(K_HOLD, s, {31'd0, hold}, {tag, ".hold"});
        expect_v(K_ERR,  s, {31'd0, err},  {tag, ".err"});
        expect_v(K_RDY,  s, {31'd0, rdy},  {tag, ".ready"});
        probe();
    endtask

    task automatic model_done(input bit s);
        int n, w;
        logic [31:0] word;
        n = nbytes(s);
        w = min_i((n + 3) / 4, depth(s));
        for (int i = 0; i < w; i++) begin
            word = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (4*i + k < n) word[8*k +: 8] = s ? bq1[4*i + k] : bq0[4*i + k];
            end
            if (s) mem1[i] = word; else mem0[i] = word;
        end
        if (!s) words0 = w;
    endtask

    task automatic send_byte(input bit s, input logic [7:0] b);
        int t;
        t = 0;
        sel = s;
        while (!(s ? rdy1 : rdy0) && t < 8) begin tick(); t++; end
        if (!(s ? rdy1 : rdy0)) begin
            checks++; errors++;
            $display("FAIL ready_timeout (dut%0d): ld_ready_o=0, expected 1", s);
        end
        ld_valid = 1'b1; ld_byte = b;
        tick();
        ld_valid = 1'b0;
        if (s) bq1.push_back(b); else bq0.push_back(b);
    endtask

    task automatic mid_status(input bit s, input string tag);
        int n;
        n = nbytes(s);
        expect_status(s, min_i(n / 4, depth(s)), 1'b1, n > 4*depth(s), 1'b1, tag);
    endtask

    task automatic start_load(input bit s, input bit junk);
        sel = s; ld_start = 1'b1;
        if (junk) begin ld_valid = 1'b1; ld_byte = 8'hFF; end
        tick();
        ld_start = 1'b0; ld_valid = 1'b0;
        if (s) bq1.delete(); else bq0.delete();
    endtask

    task automatic finish_load(input bit s, input bit with_byte, input logic [7:0] b, input string tag);
        int n, d, full;
        bit partial;
        sel = s;
        if (with_byte) begin
            ld_valid = 1'b1; ld_byte = b;
            if (s) bq1.push_back(b); else bq0.push_back(b);
        end
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0; ld_valid = 1'b0;
        n = nbytes(s); d = depth(s);
        full = min_i((n + 3) / 4, d);
        partial = (n % 4 != 0) && (n < 4*d);
        if (partial) expect_status(s, n / 4, 1'b1, 1'b0, 1'b0, {tag, ".pad"});
        else         expect_status(s, full, 1'b0, n > 4*d, 1'b0, {tag, ".run0"});
        model_done(s);
        expect_status(s, full, 1'b0, n > 4*d, 1'b0, {tag, ".run"});
    endtask

    task automatic fetch(input bit s, input logic [31:0] a, input logic [31:0] expv, input string tag);
        sel = s; ce = 1'b1; addr = a;
        expect_v(K_INST, s, expv, tag);
        probe();
        ce = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, w;
        tick(); tick();
        expect_status(1'b0, 0, 1'b1, 1'b0, 1'b1, "reset");
        expect_status(1'b1, 0, 1'b1, 1'b0, 1'b1, "reset");
        rst = 1'b1;
        tick();
        fetch(1'b0, 32'h0, NOP, "held_fetch");

        // Two full words, then done.
        send_byte(0, 8'h13); send_byte(0, 8'h00); send_byte(0, 8'h00); send_byte(0, 8'h00);
        send_byte(0, 8'h93); send_byte(0, 8'h00); send_byte(0, 8'h10); send_byte(0, 8'h00);
        finish_load(0, 1'b0, 8'h0, "two_words");
        fetch(0, 32'h0, 32'h00000013, "fetch_a0");
        fetch(0, 32'h4, 32'h00100093, "fetch_a4");
        fetch(0, 32'h6, 32'h00100093, "fetch_a6");

        // Trailing partial word gets a PAD cycle.
        start_load(0, 1'b0);
        send_byte(0, 8'h11); send_byte(0, 8'h22); send_byte(0, 8'h33); send_byte(0, 8'h44);
        send_byte(0, 8'hEE);
        finish_load(0, 1'b0, 8'h0, "pad");
        fetch(0, 32'h4, 32'h000000EE, "pad_word1");
        fetch(0, 32'h0, 32'h44332211, "pad_word0");

        // Overflow on the 4-word instance.
        for (int i = 0; i < 16; i++) send_byte(1, 8'(i + 1));
        mid_status(1, "ovf16");
        send_byte(1, 8'hA5);
        mid_status(1, "ovf17");
        finish_load(1, 1'b0, 8'h0, "ovf");
        fetch(1, 32'hC, mem1[3], "ovf_word3");
        start_load(1, 1'b0);
        expect_status(1, 0, 1'b1, 1'b0, 1'b1, "ovf_restart");

        // 4th byte with done -> straight to RUN; start beats done.
        start_load(0, 1'b1);
        send_byte(0, 8'hDE); send_byte(0, 8'hAD); send_byte(0, 8'hBE);
        finish_load(0, 1'b1, 8'hEF, "byte_done");
        sel = 0; ld_start = 1'b1; ld_done = 1'b1;
        tick();
        ld_start = 1'b0; ld_done = 1'b0; bq0.delete();
        expect_status(0, 0, 1'b1, 1'b0, 1'b1, "start_done");
        expect_status(0, 0, 1'b1, 1'b0, 1'b1, "start_done2");
        send_byte(0, 8'h01); send_byte(0, 8'h02); send_byte(0, 8'h03); send_byte(0, 8'h04);
        finish_load(0, 1'b0, 8'h0, "after_sd");
        fetch(0, 32'h0, 32'h04030201, "after_sd_w0");

        // Reset in the middle of a word.
        start_load(0, 1'b0);
        send_byte(0, 8'hAA); send_byte(0, 8'hBB);
        rst = 1'b0;
        tick();
        expect_status(0, 0, 1'b1, 1'b0, 1'b1, "mid_rst");
        rst = 1'b1;
        bq0.delete(); bq1.delete();
        send_byte(0, 8'h55); send_byte(0, 8'h66); send_byte(0, 8'h77); send_byte(0, 8'h88);
        finish_load(0, 1'b0, 8'h0, "post_rst");
        fetch(0, 32'h0, 32'h88776655, "post_rst_w0");

        // Fetch corner cases.
        sel = 0; ce = 1'b0; addr = 32'h0;
        expect_v(K_INST, 0, 32'h0, "ce_low");
        probe();
        fetch(0, 32'h0000_1000, NOP, "out_of_range");
        fetch(1, 32'h0, NOP, "small_held");

        // Randomised loads on the deep instance.
        for (int iter = 0; iter < 6; iter++) begin
            n = $urandom_range(1, 40);
            start_load(0, 1'($urandom_range(0, 1)));
            for (int i = 0; i < n - 1; i++) begin
                send_byte(0, 8'($urandom));
                repeat ($urandom_range(0, 2)) tick();
            end
            if ($urandom_range(0, 1) == 1) finish_load(0, 1'b1, 8'($urandom), "rnd");
            else begin
                send_byte(0, 8'($urandom));
                finish_load(0, 1'b0, 8'h0, "rnd");
            end
            for (int f = 0; f < 6; f++) begin
                w = $urandom_range(0, words0 - 1);
                fetch(0, 32'((w << 2) | $urandom_range(0, 3)), mem0[w], "rnd_fetch");
            end
            fetch(0, 32'($urandom) | 32'h0000_1000, NOP, "rnd_oor");
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
